// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified-memory arbiter: FSM states, read-owner tags,
// grant bit positions and byte-to-word address conversion.
package mem_arb_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

    localparam int GNT_IF = 0;
    localparam int GNT_DM = 1;
    localparam int GNT_LD = 2;
    localparam int N_REQ  = 3;

    // Drops the byte offset; callers keep only the low word-address bits the macro decodes.
    function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
        return {2'b00, byte_addr[31:2]};
    endfunction

    function automatic logic misaligned(input logic [1:0] byte_lsb);
        return |byte_lsb;
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational one-hot grant picker; zero latency, no state.
// Boot grants only the loader; run grants data over fetch unless fetch has starved.
module mem_arb_prio
    import mem_arb_pkg::*;
(
    input  logic             i_if_req,
    input  logic             i_dm_req,
    input  logic             i_ld_req,
    input  state_t           i_state,
    input  logic             i_starve_hit,
    output logic [N_REQ-1:0] o_gnt
);

    always_comb begin
        o_gnt = '0;
        if (i_state == BOOT) begin
            o_gnt[GNT_LD] = i_ld_req;
        end else if (i_starve_hit && i_if_req) begin
            o_gnt[GNT_IF] = 1'b1;
        end else if (i_dm_req) begin
            o_gnt[GNT_DM] = 1'b1;
        end else if (i_if_req) begin
            o_gnt[GNT_IF] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Shares one single-port word memory between CPU fetch, CPU data and a boot loader; grants same cycle,
// read data returns one cycle after grant. Losers are held off by withholding gnt and raising cpu_stall.
module mem_arbiter_ctrl
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_AW     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_dm_req,
    input  logic              i_dm_we,
    input  logic [ADDR_W-1:0] i_dm_addr,
    input  logic [DATA_W-1:0] i_dm_wdata,
    output logic              o_dm_gnt,
    output logic              o_dm_rvalid,
    output logic [DATA_W-1:0] o_dm_rdata,
    input  logic              i_ld_req,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [DATA_W-1:0] i_ld_wdata,
    input  logic              i_ld_done,
    output logic              o_ld_gnt,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_cpu_stall,
    output logic              o_run,
    output logic              o_err
);

    localparam int              SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);

    state_t            r_state;
    state_t            w_state_nxt;
    owner_t            r_owner;
    owner_t            w_owner_nxt;
    logic [SW-1:0]     r_starve;
    logic [SW-1:0]     w_starve_nxt;
    logic              r_err;
    logic              w_err_nxt;

    logic              w_starve_hit;
    logic [N_REQ-1:0]  w_pick;
    logic [N_REQ-1:0]  w_gnt;
    logic              w_if_gnt;
    logic              w_dm_gnt;
    logic              w_ld_gnt;
    logic              w_misalign;
    logic              w_if_rv;
    logic              w_dm_rv;
    logic [MEM_AW-1:0] w_if_waddr;
    logic [MEM_AW-1:0] w_dm_waddr;
    logic [MEM_AW-1:0] w_ld_waddr;

    assign w_if_waddr   = MEM_AW'(word_addr(32'(i_if_addr)));
    assign w_dm_waddr   = MEM_AW'(word_addr(32'(i_dm_addr)));
    assign w_ld_waddr   = MEM_AW'(word_addr(32'(i_ld_addr)));
    assign w_starve_hit = (r_starve == STARVE_LIM);

    mem_arb_prio u_prio (
        .i_if_req     (i_if_req),
        .i_dm_req     (i_dm_req),
        .i_ld_req     (i_ld_req),
        .i_state      (r_state),
        .i_starve_hit (w_starve_hit),
        .o_gnt        (w_pick)
    );

    // Reset is synchronous, so registered state is stale during the reset cycle; mask everything it drives.
    assign w_gnt    = i_rst_n ? w_pick : '0;
    assign w_if_gnt = w_gnt[GNT_IF];
    assign w_dm_gnt = w_gnt[GNT_DM];
    assign w_ld_gnt = w_gnt[GNT_LD];

    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        w_misalign  = 1'b0;
        if (w_ld_gnt) begin
            o_mem_en    = 1'b1;
            o_mem_we    = 1'b1;
            o_mem_addr  = w_ld_waddr;
            o_mem_wdata = i_ld_wdata;
            w_misalign  = misaligned(i_ld_addr[1:0]);
        end else if (w_dm_gnt) begin
            o_mem_en    = 1'b1;
            o_mem_we    = i_dm_we;
            o_mem_addr  = w_dm_waddr;
            o_mem_wdata = i_dm_we ? i_dm_wdata : '0;
            w_misalign  = misaligned(i_dm_addr[1:0]);
        end else if (w_if_gnt) begin
            o_mem_en    = 1'b1;
            o_mem_addr  = w_if_waddr;
            w_misalign  = misaligned(i_if_addr[1:0]);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if ((r_state == BOOT) && i_ld_done) begin
            w_state_nxt = RUN;
        end

        w_owner_nxt = OWN_NONE;
        if (w_dm_gnt && !i_dm_we) begin
            w_owner_nxt = OWN_DM;
        end else if (w_if_gnt) begin
            w_owner_nxt = OWN_IF;
        end

        // Counts consecutive cycles a pending fetch was refused; any fetch grant or idle fetch restarts it.
        w_starve_nxt = '0;
        if (i_if_req && !w_if_gnt) begin
            w_starve_nxt = w_starve_hit ? r_starve : r_starve + SW'(1);
        end

        w_err_nxt = r_err | w_misalign | ((r_state == RUN) & i_ld_req);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= BOOT;
            r_owner  <= OWN_NONE;
            r_starve <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_starve <= w_starve_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign w_if_rv     = i_rst_n && (r_owner == OWN_IF);
    assign w_dm_rv     = i_rst_n && (r_owner == OWN_DM);

    assign o_if_gnt    = w_if_gnt;
    assign o_dm_gnt    = w_dm_gnt;
    assign o_ld_gnt    = w_ld_gnt;
    assign o_if_rvalid = w_if_rv;
    assign o_dm_rvalid = w_dm_rv;
    assign o_if_rdata  = w_if_rv ? i_mem_rdata : '0;
    assign o_dm_rdata  = w_dm_rv ? i_mem_rdata : '0;
    assign o_run       = i_rst_n && (r_state == RUN);
    assign o_err       = i_rst_n && r_err;
    assign o_cpu_stall = !i_rst_n || (r_state == BOOT) ||
                         (i_if_req && !w_if_gnt) || (i_dm_req && !w_dm_gnt);

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Bench for mem_arbiter_ctrl: behavioural memory, a cycle-level reference model,
// a table of arbitration vectors, directed corner sequences and a randomized run.
module tb_mem_arbiter_ctrl;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, dm_req, dm_we, ld_req, ld_done;
    logic [31:0] if_addr, dm_addr, dm_wdata, ld_addr, ld_wdata;
    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, ld_gnt;
    logic [31:0] if_rdata, dm_rdata;
    logic        mem_en, mem_we, cpu_stall, run, err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mem [0:1023];

    int checks   = 0;
    int failures = 0;

    mem_arbiter_ctrl #(.ADDR_W(32), .DATA_W(32), .MEM_AW(10), .STARVE_MAX(STARVE_MAX)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt),
        .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
        .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
        .o_dm_gnt(dm_gnt), .o_dm_rvalid(dm_rvalid), .o_dm_rdata(dm_rdata),
        .i_ld_req(ld_req), .i_ld_addr(ld_addr), .i_ld_wdata(ld_wdata), .i_ld_done(ld_done),
        .o_ld_gnt(ld_gnt),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata),
        .o_cpu_stall(cpu_stall), .o_run(run), .o_err(err)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    // Reference model state
    bit          m_boot = 1'b1;
    int          m_starve = 0;
    bit          m_err = 1'b0;
    int          m_pend = 0;
    logic [31:0] m_pend_data = '0;
    logic [31:0] m_mem [0:1023];

    logic        e_if_gnt, e_dm_gnt, e_ld_gnt, e_en, e_we, e_stall, e_run, e_err;
    logic        e_if_rv, e_dm_rv;
    logic [9:0]  e_addr;
    logic [31:0] e_wdata, e_if_rd, e_dm_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic predict();
        e_if_gnt = 0; e_dm_gnt = 0; e_ld_gnt = 0; e_en = 0; e_we = 0;
        e_addr = '0; e_wdata = '0; e_if_rv = 0; e_dm_rv = 0; e_if_rd = '0; e_dm_rd = '0;
        if (!rst_n) begin
            e_stall = 1; e_run = 0; e_err = 0;
        end else begin
            e_ld_gnt = m_boot && ld_req;
            e_if_gnt = !m_boot && if_req && (m_starve >= STARVE_MAX || !dm_req);
            e_dm_gnt = !m_boot && dm_req && !e_if_gnt;
            if (e_ld_gnt) begin
                e_en = 1; e_we = 1; e_addr = 10'(ld_addr >> 2); e_wdata = ld_wdata;
            end else if (e_dm_gnt) begin
                e_en = 1; e_we = dm_we; e_addr = 10'(dm_addr >> 2); e_wdata = dm_we ? dm_wdata : 32'h0;
            end else if (e_if_gnt) begin
                e_en = 1; e_addr = 10'(if_addr >> 2);
            end
            e_stall = m_boot || (if_req && !e_if_gnt) || (dm_req && !e_dm_gnt);
            e_run   = !m_boot;
            e_err   = m_err;
            e_if_rv = (m_pend == 1);
            e_dm_rv = (m_pend == 2);
            e_if_rd = e_if_rv ? m_pend_data : 32'h0;
            e_dm_rd = e_dm_rv ? m_pend_data : 32'h0;
        end
    endtask

    task automatic model_update();
        bit mis;
        mis = 0;
        if (!rst_n) begin
            m_boot = 1; m_starve = 0; m_err = 0; m_pend = 0; m_pend_data = '0;
        end else begin
            m_pend = 0;
            if (e_ld_gnt) begin
                m_mem[e_addr] = ld_wdata;
                mis = (ld_addr[1:0] != 2'b00);
            end
            if (e_dm_gnt) begin
                mis = (dm_addr[1:0] != 2'b00);
                if (dm_we) m_mem[e_addr] = dm_wdata;
                else begin m_pend = 2; m_pend_data = m_mem[e_addr]; end
            end
            if (e_if_gnt) begin
                mis = (if_addr[1:0] != 2'b00);
                m_pend = 1; m_pend_data = m_mem[e_addr];
            end
            if (if_req && !e_if_gnt) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
            else                     m_starve = 0;
            if (mis || (!m_boot && ld_req)) m_err = 1;
            if (m_boot && ld_done) m_boot = 0;
        end
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic step_begin();
        #2;
        predict();
        chk("m_if_gnt", if_gnt, e_if_gnt);
        chk("m_dm_gnt", dm_gnt, e_dm_gnt);
        chk("m_ld_gnt", ld_gnt, e_ld_gnt);
        chk("m_mem_en", mem_en, e_en);
        chk("m_mem_we", mem_we, e_we);
        chk("m_mem_addr", mem_addr, e_addr);
        chk("m_mem_wdata", mem_wdata, e_wdata);
        chk("m_stall", cpu_stall, e_stall);
        chk("m_run", run, e_run);
        chk("m_err", err, e_err);
        chk("m_if_rvalid", if_rvalid, e_if_rv);
        chk("m_if_rdata", if_rdata, e_if_rd);
        chk("m_dm_rvalid", dm_rvalid, e_dm_rv);
        chk("m_dm_rdata", dm_rdata, e_dm_rd);
    endtask

    task automatic step_end();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req = 0; dm_req = 0; dm_we = 0; ld_req = 0; ld_done = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; ld_addr = '0; ld_wdata = '0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 15)) << 2;
        if ($urandom_range(0, 15) == 0) a = a | 32'($urandom_range(1, 3));
        return a;
    endfunction

    typedef struct {
        logic if_req;
        logic dm_req;
        logic dm_we;
        logic e_if;
        logic e_dm;
        logic e_stall;
        logic e_dm_rv;
    } vec_t;

    vec_t tbl [11];

    initial begin
        // if, dm, we | exp if_gnt, dm_gnt, stall, dm_rvalid
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 1024; i++) begin mem[i] = '0; m_mem[i] = '0; end
        mem_rdata = '0;
        rst_n = 0;
        idle_inputs();
        @(negedge clk);

        // Reset state, with requests present to show they are masked
        step_begin(); step_end();
        if_req = 1; ld_req = 1;
        step_begin();
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_ld_gnt", ld_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_stall", cpu_stall, 1);
        chk("rst_run", run, 0);
        chk("rst_err", err, 0);
        step_end();
        rst_n = 1; idle_inputs();

        // Boot load: two words, done pulse coincident with the second write
        ld_req = 1; ld_addr = 32'h0; ld_wdata = 32'h8C200000;
        step_begin();
        chk("boot_ld_gnt0", ld_gnt, 1);
        chk("boot_stall", cpu_stall, 1);
        step_end();
        ld_addr = 32'h4; ld_wdata = 32'h8C220001; ld_done = 1;
        step_begin();
        chk("boot_ld_gnt1", ld_gnt, 1);
        chk("boot_mem_addr1", mem_addr, 1);
        chk("boot_run_pre", run, 0);
        step_end();
        idle_inputs();
        step_begin();
        chk("boot_run", run, 1);
        chk("boot_stall_idle", cpu_stall, 0);
        chk("boot_mem_w0", mem[0], 32'h8C200000);
        chk("boot_mem_w1", mem[1], 32'h8C220001);
        step_end();

        // Fetch stream
        if_req = 1; if_addr = 32'h0;
        step_begin(); chk("fs_gnt0", if_gnt, 1); chk("fs_rv0", if_rvalid, 0); step_end();
        if_addr = 32'h4;
        step_begin(); chk("fs_gnt1", if_gnt, 1); chk("fs_rv1", if_rvalid, 1);
        chk("fs_rd1", if_rdata, 32'h8C200000); step_end();
        if_addr = 32'h8;
        step_begin(); chk("fs_gnt2", if_gnt, 1); chk("fs_rd2", if_rdata, 32'h8C220001); step_end();
        idle_inputs();
        step_begin(); chk("fs_rv3", if_rvalid, 1); chk("fs_rd3", if_rdata, 32'h0); step_end();
        step_begin(); chk("fs_rv_idle", if_rvalid, 0); step_end();

        // Table: starvation, contention, store
        for (int i = 0; i < 11; i++) begin
            if_req = tbl[i].if_req; if_addr = 32'h0;
            dm_req = tbl[i].dm_req; dm_we = tbl[i].dm_we; dm_addr = 32'h24; dm_wdata = 32'h0000000B;
            step_begin();
            chk($sformatf("tbl%0d_if_gnt", i), if_gnt, tbl[i].e_if);
            chk($sformatf("tbl%0d_dm_gnt", i), dm_gnt, tbl[i].e_dm);
            chk($sformatf("tbl%0d_stall", i), cpu_stall, tbl[i].e_stall);
            chk($sformatf("tbl%0d_dm_rv", i), dm_rvalid, tbl[i].e_dm_rv);
            step_end();
        end
        idle_inputs();

        // Load back the stored word
        dm_req = 1; dm_addr = 32'h24;
        step_begin(); chk("ld24_gnt", dm_gnt, 1); step_end();
        idle_inputs();
        step_begin(); chk("ld24_rv", dm_rvalid, 1); chk("ld24_rd", dm_rdata, 32'h0000000B); step_end();

        // Loader request during run
        ld_req = 1; ld_addr = 32'h40; ld_wdata = 32'hDEADBEEF;
        step_begin(); chk("ldrun_gnt", ld_gnt, 0); chk("ldrun_en", mem_en, 0); chk("ldrun_err0", err, 0); step_end();
        idle_inputs();
        step_begin(); chk("ldrun_err1", err, 1); step_end();

        // Reset while a data read is in flight
        dm_req = 1; dm_addr = 32'h24;
        step_begin(); chk("rmr_gnt", dm_gnt, 1); step_end();
        idle_inputs(); rst_n = 0;
        step_begin(); chk("rmr_rv", dm_rvalid, 0); chk("rmr_stall", cpu_stall, 1); step_end();
        rst_n = 1;
        step_begin(); chk("rmr_rv2", dm_rvalid, 0); chk("rmr_run", run, 0);
        chk("rmr_err", err, 0); chk("rmr_stall2", cpu_stall, 1); step_end();

        // Leave boot with no writes, then a misaligned fetch
        ld_done = 1;
        step_begin(); step_end();
        idle_inputs();
        if_req = 1; if_addr = 32'h6;
        step_begin(); chk("mis_gnt", if_gnt, 1); chk("mis_addr", mem_addr, 1); chk("mis_err0", err, 0); step_end();
        idle_inputs();
        step_begin(); chk("mis_err1", err, 1); chk("mis_rd", if_rdata, 32'h8C220001); step_end();

        // Randomized traffic; requesters hold until granted, loader drops after one cycle
        for (int n = 0; n < 3000; n++) begin
            bit gi, gd, rr;
            rst_n = ($urandom_range(0, 299) != 0);
            if (!if_req && $urandom_range(0, 1) == 1) begin if_req = 1; if_addr = rand_addr(); end
            if (!dm_req && $urandom_range(0, 1) == 1) begin
                dm_req = 1; dm_we = 1'($urandom_range(0, 1)); dm_addr = rand_addr(); dm_wdata = $urandom;
            end
            ld_req = m_boot ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 63) == 0);
            ld_addr = rand_addr(); ld_wdata = $urandom;
            ld_done = m_boot && ($urandom_range(0, 7) == 0);
            step_begin();
            gi = e_if_gnt; gd = e_dm_gnt; rr = !rst_n;
            step_end();
            if (gi || rr) if_req = 0;
            if (gd || rr) dm_req = 0;
            ld_req = 0; ld_done = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_ctrl.md
# mem_arbiter_ctrl

Controller that shares one single-port synchronous word memory between the CPU_MIPS_32b_5stage instruction-fetch port, its data (load/store) port, and a host program loader. Sequences a boot phase, in which only the loader writes the program image and the CPU is stalled, then a run phase that arbitrates fetch against data access with starvation protection. It sits between the CPU's memory ports and the unified memory macro and drives the pipeline stall.

## Interface
- ADDR_W, 32, CPU byte-address width
- DATA_W, 32, word width
- MEM_AW, 10, memory word-address width (1024 words)
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch is forced to win
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- if_req / if_addr  in  1 / ADDR_W  fetch read request, byte address
- if_gnt  out  1  fetch granted this cycle
- if_rvalid / if_rdata  out  1 / DATA_W  fetch read data return
- dm_req / dm_we / dm_addr / dm_wdata  in  1 / 1 / ADDR_W / DATA_W  data request
- dm_gnt  out  1  data granted this cycle
- dm_rvalid / dm_rdata  out  1 / DATA_W  load data return
- ld_req / ld_addr / ld_wdata  in  1 / ADDR_W / DATA_W  loader write request
- ld_done  in  1  single-cycle pulse ending boot phase
- ld_gnt  out  1  loader write accepted
- mem_en / mem_we / mem_addr / mem_wdata  out  1 / 1 / MEM_AW / DATA_W  memory strobes
- mem_rdata  in  DATA_W  memory read data, one cycle after mem_en & !mem_we
- cpu_stall  out  1  freeze pipeline
- run  out  1  high in run phase
- err  out  1  sticky protocol error

## Operation
- States: BOOT, RUN. Reset -> BOOT. BOOT -> RUN on ld_done. RUN is left only by reset.
- BOOT: ld_req granted every cycle (ld_gnt=ld_req); if_gnt=dm_gnt=0; cpu_stall=1.
- RUN priority: dm > if, unless starve counter == STARVE_MAX and if_req, then if wins. ld_req in RUN: ld_gnt=0, err set.
- Starve counter: +1 (saturating at STARVE_MAX) each cycle if_req & !if_gnt; cleared on if_gnt or !if_req.
- Address: mem_addr = addr[MEM_AW+1:2]. Any granted request with addr[1:0]!=0 sets err; the access still proceeds on the truncated address.
- Memory strobes driven only for the granted requester; mem_en=0 when no grant; mem_wdata=0 when not writing.
- Read owner register records who (if / dm / none) issued a read; next cycle routes mem_rdata to that requester's rdata and pulses its rvalid. Writes produce no rvalid.
- cpu_stall = BOOT | (if_req & !if_gnt) | (dm_req & !dm_gnt).

## Timing
- Grants are combinational from req and registered state, same cycle. Requesters hold req/addr/wdata until gnt.
- Read latency: rvalid exactly 1 cycle after gnt; back-to-back reads sustain 1 per cycle.
- ld_done with ld_req in same cycle: that write completes; RUN from next cycle, first CPU grant possible then.
- Reset values: if_gnt, dm_gnt, ld_gnt, if_rvalid, dm_rvalid, mem_en, mem_we, run, err = 0; rdata, mem_addr, mem_wdata = 0; cpu_stall = 1; starve counter 0; owner none.
- Reset during an outstanding read: pending rvalid is dropped and owner cleared.
- if_req and dm_req both present for STARVE_MAX cycles: dm granted STARVE_MAX cycles, fetch granted the next, then counter 0.

## Structure
- Package mem_arb_pkg: state enum {BOOT, RUN}, owner enum {OWN_NONE, OWN_IF, OWN_DM}, word-address function.
- Sub-module mem_arb_prio: combinational grant picker (inputs: reqs, state, starve_hit; outputs: one-hot grant). All registers live in mem_arbiter_ctrl.

## Test plan
- Boot load: ld writes 0x8C200000, 0x8C220001 to byte addresses 0x0, 0x4, ld_done -> mem shows words 0,1 written; run=1 next cycle; cpu_stall=0 if no req pending.
- Fetch stream: if_req continuous from 0x0 -> if_gnt every cycle, if_rdata equals loaded words, if_rvalid 1 cycle after each gnt.
- Contention: if_req and dm_req (load 0x24) held 6 cycles, STARVE_MAX=4 -> dm gnt cycles 0-3, if gnt cycle 4, dm gnt cycle 5; cpu_stall high while either waits.
- Store then load: dm_we to 0x24 with 0x0000000B, then load 0x24 -> dm_rvalid with 0x0000000B, no rvalid on the store.
- Errors: ld_req in RUN -> ld_gnt=0, err=1; fetch 0x6 -> err=1, reads word 1.
- Reset mid-read: rst_n low in the cycle after a dm read grant -> dm_rvalid stays 0, state BOOT, cpu_stall=1.
